// File: rtl/lru_access_arbiter.sv
// Round-robin front end for a shared LRU buffer: grants one requester,
// drives a single set strobe into buffer_lru and reports hit and slot.
module lru_access_arbiter #(
  parameter int WIDTH    = 16,
  parameter int BUF_SIZE = 8,
  parameter int N_REQ    = 4,
  parameter int IDX_W    = $clog2(BUF_SIZE),
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*WIDTH-1:0]    req_val_i,
  input  logic                      flush_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic                      resp_valid_o,
  output logic [ID_W-1:0]           resp_id_o,
  output logic                      resp_hit_o,
  output logic [IDX_W-1:0]          resp_idx_o,
  output logic                      resp_err_o,
  output logic                      busy_o,
  output logic                      lru_rst_o,
  output logic                      lru_set_o,
  output logic [WIDTH-1:0]          lru_val_o,
  input  logic [BUF_SIZE*WIDTH-1:0] lru_bufs_i
);

  localparam int CNT_W = $clog2(BUF_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ISSUE,
    SETTLE,
    RESP
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_r;
  logic [WIDTH-1:0] val_r;
  logic [CNT_W-1:0] fill_cnt;
  logic             hit_r;
  logic             flush_r;

  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic             m_any;
  logic [IDX_W-1:0] m_idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_vld && req_i[(int'(rr_ptr) + i) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  // Only occupied slots may match, so a zero value never hits empty ones.
  always_comb begin
    m_any = 1'b0;
    m_idx = '0;
    for (int k = 0; k < BUF_SIZE; k++) begin
      if (!m_any && (CNT_W'(k) < fill_cnt) &&
          (lru_bufs_i[k*WIDTH +: WIDTH] == val_r)) begin
        m_any = 1'b1;
        m_idx = IDX_W'(k);
      end
    end
  end

  assign busy_o    = (state != IDLE);
  assign lru_rst_o = rst_i | flush_r;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_r         <= '0;
      val_r        <= '0;
      fill_cnt     <= '0;
      hit_r        <= 1'b0;
      flush_r      <= 1'b0;
      ack_o        <= '0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= '0;
      resp_hit_o   <= 1'b0;
      resp_idx_o   <= '0;
      resp_err_o   <= 1'b0;
      lru_set_o    <= 1'b0;
      lru_val_o    <= '0;
    end else begin
      flush_r      <= 1'b0;
      lru_set_o    <= 1'b0;
      ack_o        <= '0;
      resp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_i) begin
            flush_r  <= 1'b1;
            fill_cnt <= '0;
          end else if (gnt_vld) begin
            id_r      <= gnt_id;
            val_r     <= req_val_i[gnt_id*WIDTH +: WIDTH];
            lru_val_o <= req_val_i[gnt_id*WIDTH +: WIDTH];
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_r <= m_any;
          if (!m_any && (fill_cnt < CNT_W'(BUF_SIZE)))
            fill_cnt <= fill_cnt + 1'b1;
          lru_set_o <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          state <= SETTLE;
        end
        // Buffer has absorbed the set by now; register the response.
        SETTLE: begin
          resp_valid_o <= 1'b1;
          ack_o        <= N_REQ'(1) << id_r;
          resp_id_o    <= id_r;
          resp_hit_o   <= hit_r;
          resp_err_o   <= !m_any;
          resp_idx_o   <= m_any ? m_idx : '0;
          state        <= RESP;
        end
        RESP: begin
          rr_ptr <= (int'(id_r) == N_REQ - 1) ? '0 : id_r + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lru_access_arbiter.sv
// Bench for lru_access_arbiter with a behavioural buffer_lru model
// and a response scoreboard keyed on requester, hit, slot and cycle.
module tb_lru_access_arbiter;

  localparam int W   = 16;
  localparam int BS  = 8;
  localparam int NR  = 4;
  localparam int IW  = 3;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_val;
  logic            flush;
  logic [NR-1:0]   ack;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic            resp_hit;
  logic [IW-1:0]   resp_idx;
  logic            resp_err;
  logic            busy;
  logic            lru_rst;
  logic            lru_set;
  logic [W-1:0]    lru_val;
  logic [BS*W-1:0] bufs;

  lru_access_arbiter #(.WIDTH(W), .BUF_SIZE(BS), .N_REQ(NR)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_val_i(req_val),
    .flush_i(flush), .ack_o(ack), .resp_valid_o(resp_valid),
    .resp_id_o(resp_id), .resp_hit_o(resp_hit),
    .resp_idx_o(resp_idx), .resp_err_o(resp_err), .busy_o(busy),
    .lru_rst_o(lru_rst), .lru_set_o(lru_set), .lru_val_o(lru_val),
    .lru_bufs_i(bufs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // buffer_lru: in-order fill, entries stay put, LRU slot replaced
  logic [W-1:0] mem [BS];
  int stamp [BS];
  int bcnt = 0;
  int tick = 0;

  always @(posedge clk) begin
    int h, v;
    if (lru_rst) begin
      bcnt <= 0;
      tick <= 0;
      for (int k = 0; k < BS; k++) begin
        mem[k]   <= '0;
        stamp[k] <= 0;
      end
    end else if (lru_set) begin
      h = -1;
      for (int k = 0; k < BS; k++)
        if (h < 0 && k < bcnt && mem[k] == lru_val) h = k;
      if (h >= 0) v = h;
      else if (bcnt < BS) begin
        v = bcnt;
        bcnt <= bcnt + 1;
      end else begin
        v = 0;
        for (int k = 1; k < BS; k++)
          if (stamp[k] < stamp[v]) v = k;
      end
      mem[v]   <= lru_val;
      stamp[v] <= tick + 1;
      tick     <= tick + 1;
    end
  end

  always_comb begin
    bufs = '0;
    for (int k = 0; k < BS; k++) bufs[k*W +: W] = mem[k];
  end

  int cmp = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct { int id; int hit; int idx; int cy; } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (q.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        e = q.pop_front();
        chk("resp_id", int'(resp_id), e.id);
        chk("resp_hit", int'(resp_hit), e.hit);
        chk("resp_idx", int'(resp_idx), e.idx);
        chk("resp_err", int'(resp_err), 0);
        chk("resp_cycle", cyc, e.cy);
        chk("ack_onehot", int'(ack), 1 << e.id);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_ack(input int id);
    int n = 0;
    while (!ack[id] && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!ack[id]) chk("ack_timeout", id, -1);
    req[id] = 1'b0;
  endtask

  task automatic send(input int id, input int val,
                      input int hit, input int idx);
    wait_idle();
    req_val[id*W +: W] = W'(val);
    req[id] = 1'b1;
    q.push_back('{id, hit, idx, cyc + 4});
    wait_ack(id);
  endtask

  task automatic do_flush();
    wait_idle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_pulse", int'(lru_rst), 1);
    chk("flush_fill", int'(dut.fill_cnt), 0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_end", int'(lru_rst), 0);
  endtask

  typedef struct { int id; int val; int hit; int idx; } vec_t;
  vec_t tab [14];

  initial begin
    int n;
    tab = '{'{0, 100, 0, 0}, '{0, 101, 0, 1}, '{0, 102, 0, 2},
            '{0, 103, 0, 3}, '{0, 101, 1, 1}, '{0, 104, 0, 4},
            '{0, 105, 0, 5}, '{0, 106, 0, 6}, '{0, 107, 0, 7},
            '{0, 108, 0, 0}, '{0, 109, 0, 2}, '{0, 110, 0, 3},
            '{0, 110, 1, 3}, '{0, 111, 0, 1}};
    rst = 1'b1;
    req = '0;
    req_val = '0;
    flush = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk("rst_lru_rst", int'(lru_rst), 1);
      chk("rst_outputs", int'({ack, resp_valid, resp_id, resp_hit,
          resp_idx, resp_err, busy, lru_set, lru_val} != 0), 0);
    end
    rst = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || lru_set || lru_rst) n++;
    end
    chk("idle_quiet", n, 0);

    for (int i = 0; i < 14; i++) begin
      send(tab[i].id, tab[i].val, tab[i].hit, tab[i].idx);
      if (i == 4) chk("fill_cnt_4", int'(dut.fill_cnt), 4);
    end
    chk("fill_cnt_sat", int'(dut.fill_cnt), 8);

    do_flush();
    send(0, 300, 0, 0);
    send(0, 301, 0, 1);
    send(0, 302, 0, 2);
    do_flush();
    send(0, 0, 0, 0);
    send(1, 0, 1, 0);

    wait_idle();
    req_val[2*W +: W] = 16'd77;
    req[2] = 1'b1;
    n = 0;
    while (!lru_set && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("abort_set_seen", int'(lru_set), 1);
    rst = 1'b1;
    req[2] = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_set", int'(lru_set), 0);
    chk("abort_ack", int'(ack), 0);
    chk("abort_lru_rst", int'(lru_rst), 1);
    rst = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("abort_no_resp", n, 0);
    send(3, 77, 0, 0);

    wait_idle();
    for (int k = 0; k < NR; k++) begin
      req_val[k*W +: W] = W'(200 + k);
      req[k] = 1'b1;
      q.push_back('{k, 0, k + 1, cyc + 4 + 5 * k});
    end
    for (int k = 0; k < NR; k++) wait_ack(k);

    wait_idle();
    req_val[1*W +: W] = 16'd210;
    req_val[3*W +: W] = 16'd211;
    req[1] = 1'b1;
    req[3] = 1'b1;
    q.push_back('{1, 0, 5, cyc + 4});
    q.push_back('{3, 0, 6, cyc + 9});
    wait_ack(1);
    wait_ack(3);

    wait_idle();
    req_val[1*W +: W] = 16'd220;
    req[1] = 1'b1;
    q.push_back('{1, 0, 7, cyc + 4});
    @(negedge clk);
    req[1] = 1'b0;
    req_val[1*W +: W] = 16'd999;
    wait_ack(1);

    send(0, 230, 0, 0);
    send(2, 203, 1, 4);

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule

// File: doc/lru_access_arbiter.md
Name: lru_access_arbiter

Overview:
- Controller and arbiter that shares one buffer_lru instance (BUF_SIZE entries of WIDTH bits, LRU replacement, in-order fill from slot 0) among N_REQ requesters.
- Grants requesters round-robin and performs a hit lookup against the buffer contents.
- Issues a one-cycle set pulse to the buffer, then reports hit/miss and the final slot index back to the granted requester.
- Also sequences buffer flushes. Sits between client logic and buffer_lru; the buffer is external and connected through the lru_* ports.

Parameters:
- WIDTH, 16, data width of a buffer entry.
- BUF_SIZE, 8, number of buffer entries.
- N_REQ, 4, number of requesters.
- IDX_W, $clog2(BUF_SIZE), slot index width (derived).
- ID_W, $clog2(N_REQ), requester id width (derived).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  N_REQ  per-requester request; held high until matching ack_o.
- req_val_i  in  N_REQ*WIDTH  per-requester value; slice k = [k*WIDTH +: WIDTH]; stable while req_i[k] is high.
- flush_i  in  1  request to clear the buffer; level, sampled in IDLE.
- ack_o  out  N_REQ  one-hot one-cycle pulse to the served requester.
- resp_valid_o  out  1  one-cycle pulse; resp_* fields valid.
- resp_id_o  out  ID_W  served requester index.
- resp_hit_o  out  1  value was already present before insertion.
- resp_idx_o  out  IDX_W  slot holding the value after insertion.
- resp_err_o  out  1  value not found after insertion (buffer fault).
- busy_o  out  1  state != IDLE.
- lru_rst_o  out  1  reset to buffer_lru (rst_i OR flush pulse).
- lru_set_o  out  1  set strobe to buffer_lru.
- lru_val_o  out  WIDTH  value to buffer_lru.
- lru_bufs_i  in  BUF_SIZE*WIDTH  buffer_lru buf_array_o; entry k = [k*WIDTH +: WIDTH].

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE, rr_ptr=0, fill_cnt=0.
  - All outputs 0 except lru_rst_o=1 while rst_i is high.
  - Reset mid-operation aborts the transaction: no ack, no resp, lru_set_o low the next cycle.
- fill_cnt (width $clog2(BUF_SIZE+1)):
  - Number of occupied slots. Slots with index < fill_cnt are valid.
  - Comparisons ignore slots >= fill_cnt, so a value of 0 never matches an empty slot.
- FSM IDLE -> LOOKUP -> ISSUE -> SETTLE -> RESP -> IDLE; one request per 5 cycles.
- IDLE:
  - If flush_i: lru_rst_o=1 for exactly one cycle (next cycle), fill_cnt<=0, stay in IDLE, ignore requests this cycle. Flush has priority over requests.
  - Else if any req_i: grant the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ. Latch id and value; go to LOOKUP.
- LOOKUP:
  - hit_r = any valid slot equals the latched value.
  - If miss and fill_cnt < BUF_SIZE: fill_cnt += 1. Saturates at BUF_SIZE.
  - Go to ISSUE.
- ISSUE: lru_set_o=1 and lru_val_o=latched value for exactly one cycle; go to SETTLE.
- SETTLE: lru_set_o=0; wait one cycle for buffer output to update; go to RESP.
- RESP:
  - Search valid slots for the value; lowest matching index goes to resp_idx_o.
  - resp_valid_o=1, ack_o[id]=1, resp_id_o=id, resp_hit_o=hit_r.
  - If no match: resp_err_o=1 and resp_idx_o=0.
  - rr_ptr <= (id+1) mod N_REQ; go to IDLE.
- Latency: req first seen in IDLE at cycle 0 -> lru_set_o at cycle 2 -> ack/resp at cycle 4.
- lru_val_o holds the last latched value outside ISSUE; only lru_set_o is meaningful.
- Requests arriving while busy wait. A requester dropping req_i before ack is still served, and the value latched at grant is used.
- req_i changes during a transaction do not affect the in-flight grant.

Test Plan:
- Reset then idle: rst_i=1 for 5 cycles -> lru_rst_o=1, all other outputs 0. Release with no req -> busy_o=0, lru_set_o never asserted.
- Single requester fill and hit, req0 with 100,101,102,103,101:
  - Each ack arrives 4 cycles after the req is seen.
  - resp_idx = 0,1,2,3,1.
  - resp_hit = 0,0,0,0,1.
  - fill_cnt ends at 4.
- LRU eviction via controller: continue with 104..107 (idx 4..7), then 108 -> hit=0, idx=0; 109 -> idx=2; 110 -> idx=3; 110 again -> hit=1, idx=3; 111 -> idx=1.
- Round-robin: req0..req3 all high at once with 200..203 and held -> acks in order 0,1,2,3, 5 cycles apart. Re-assert req1 and req3 only -> ack 1 then 3.
- Flush and zero value: after 3 inserts, flush_i in IDLE -> lru_rst_o pulses 1 cycle, fill_cnt=0. Then insert 0 -> resp_hit=0, idx=0.
- Reset mid-operation: assert rst_i during ISSUE -> no ack/resp, state IDLE next cycle. Re-request the same value -> hit=0, idx=0.
